// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple adder processes one nibble per cycle,
// with the carry held in a register between nibbles and a valid/ready handshake on each side.

module four_bit_adder_bh (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [WIDTH-1:0] res_next;
    logic [3:0]       a_nib, b_nib, add_sum;
    logic             add_co;
    logic             last_nib;
    logic             overflow_next;

    assign a_nib    = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_nib    = b_reg[{idx_reg, 2'b00} +: 4];
    assign last_nib = (idx_reg == IW'(NIB - 1));

    four_bit_adder_bh u_add (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_reg),
        .s  (add_sum),
        .co (add_co)
    );

    // res_next is the partial result with the current nibble merged in; on the
    // last nibble it is the complete sum that gets loaded into sum_out.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign res_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? add_sum : res_reg[4*gi +: 4];
        end
    endgenerate

    assign overflow_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res_next[WIDTH-1] != a_reg[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_nib)    state_next = DONE;
            DONE:    if (res_ready)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_reg == IDLE);
        res_valid   = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            sum_out   <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        carry_reg <= c_in;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= add_co;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_nib) begin
                        sum_out  <= res_next;
                        c_out    <= add_co;
                        overflow <= overflow_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder (WIDTH=16) against a plain
// arithmetic reference model, with a scoreboard on the result handshake.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in, b_in;
    logic             c_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    logic [WIDTH-1:0] last_sum = '0;
    logic [17:0] exp_q[$];
    int          acc_q[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum_out     (sum_out),
        .c_out       (c_out),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {overflow, c_out, sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b} + {16'h0, c};
        ov = (a[15] == b[15]) && (s[15] != a[15]);
        return {ov, s};
    endfunction

    // Scoreboard: sampled just after the falling edge, i.e. the values the next rising edge sees.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (start_valid && start_ready) begin
                    exp_q.push_back(model(a_in, b_in, c_in));
                    acc_q.push_back(cyc);
                end
                if (res_valid && res_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("sb_spurious", 1, 0);
                    end else begin
                        logic [17:0] e;
                        e = exp_q.pop_front();
                        check("sb_result", {13'h0, overflow, c_out, sum_out}, {14'h0, e});
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input int hold, input bit expect_now);
        logic [17:0] m;
        int w, lat;
        m = model(a, b, c);
        w = 0;
        while (!start_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (expect_now) check("accept_next", w, 0);
        check("ready_idle", start_ready, 1);
        start_valid = 1'b1;
        a_in = a; b_in = b; c_in = c;
        res_ready = 1'b0;
        @(negedge clk);
        start_valid = (hold > 0);
        a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
        check("ready_run", start_ready, 0);
        lat = 0;
        while (!res_valid && lat < 20) begin
            check("sum_hold_run", sum_out, last_sum);
            res_ready = (hold == 0) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIB);
        check("sum", sum_out, m[15:0]);
        check("c_out", c_out, m[16]);
        check("overflow", overflow, m[17]);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            start_valid = 1'b1;
            a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_ready", start_ready, 0);
            check("hold_sum", {15'h0, overflow, c_out, sum_out}, {14'h0, m});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hs_valid", res_valid, 0);
        check("hs_ready", start_ready, 1);
        last_sum = m[15:0];
        $display("op a=%04h b=%04h c=%0d -> sum=%04h c_out=%0d ov=%0d lat=%0d",
                 a, b, c, sum_out, c_out, overflow, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, h0, w;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", c_out, 0);
        check("rst_ov", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        run_op(16'hABCD, 16'h1357, 1'b1, 10, 1'b0);
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        start_valid = 1'b0;
        @(negedge clk);

        // Reset two cycles into RUN discards the operation.
        start_valid = 1'b1; a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_sum", sum_out, 0);
        check("arst_cout", c_out, 0);
        check("arst_ov", overflow, 0);
        check("arst_valid", res_valid, 0);
        check("arst_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = '0;
        run_op(16'h0F0F, 16'h0101, 1'b0, 0, 1'b0);

        // Back-to-back with start_valid and res_ready held high.
        n0 = acc_q.size();
        h0 = hs_cnt;
        start_valid = 1'b1; res_ready = 1'b1;
        a_in = 16'h5A5A; b_in = 16'hA5A5; c_in = 1'b1;
        @(negedge clk);
        a_in = 16'h8001; b_in = 16'hC003; c_in = 1'b0;
        w = 0;
        while (acc_q.size() < n0 + 2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        start_valid = 1'b0;
        check("b2b_accepts", acc_q.size() - n0, 2);
        if (acc_q.size() >= n0 + 2)
            check("b2b_spacing", acc_q[n0 + 1] - acc_q[n0], NIB + 2);
        w = 0;
        while (hs_cnt < h0 + 2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        res_ready = 1'b0;
        check("b2b_results", hs_cnt - h0, 2);
        check("b2b_last_sum", sum_out, 16'h4004);
        $display("b2b accepts at cycles %0d and %0d", acc_q[n0], acc_q[acc_q.size() - 1]);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built on one instance of the team's 4-bit ripple adder, four_bit_adder_bh.
- Sits around that adder. Feeds it one operand nibble pair per cycle, with the carry registered between cycles, and collects each 4-bit sum into a result register.
- Upstream interface: valid/ready operand port. Downstream interface: valid/ready result port.
- Trades latency for area in datapaths wider than 4 bits.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. NIB = WIDTH/4 nibbles.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operand request
- start_ready  output  1  block can accept operands; equals (state==IDLE)
- a_in  input  WIDTH  operand A, sampled at accept
- b_in  input  WIDTH  operand B, sampled at accept
- c_in  input  1  carry-in, sampled at accept
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  registered sum
- c_out  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock and reset. rst_n is asynchronous, active-low; clk is the single clock.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, nibble index=0, carry reg=0, operand regs=0.
  - sum_out=0, c_out=0, overflow=0, res_valid=0.
  - start_ready=1 once in IDLE.
  - An in-flight operation is discarded; nothing is emitted.
- FSM states IDLE, RUN, DONE:
  - IDLE: start_ready=1. Accept on an edge with start_valid&&start_ready: latch a_in, b_in; carry reg<=c_in; idx<=0; go to RUN.
  - RUN: the adder sees a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry reg. On each edge, write the adder sum into res_reg[4*idx+:4], carry reg<=adder c_out, idx<=idx+1. On the edge where idx==NIB-1, go to DONE and load the output registers.
  - Output load: sum_out<=final result, c_out<=final adder c_out, overflow<=(a_reg[W-1]==b_reg[W-1]) && (final sum[W-1]!=a_reg[W-1]); res_valid<=1.
  - DONE: res_valid=1. sum_out, c_out, overflow held stable. start_ready=0; start_valid is ignored. On an edge with res_valid&&res_ready: res_valid<=0, go to IDLE.
- Latency: res_valid rises NIB edges after the accept edge.
- Throughput: minimum NIB+2 cycles per operation (IDLE accept, NIB RUN cycles, DONE handshake). There is no accept in the DONE cycle.
- sum_out, c_out and overflow change only at the RUN->DONE load or at reset. They hold the previous result through IDLE/RUN of the next operation.
- Operand inputs changing after accept have no effect.
- res_ready held high before DONE has no effect. res_ready low in DONE holds indefinitely.
- Carry chaining: nibble 0 uses the latched c_in; nibble k uses the carry out of nibble k-1. Arithmetic is modulo 2^WIDTH, with c_out as bit WIDTH.

Test Plan:
- WIDTH=16; reset; a=0x1234, b=0x4321, c_in=0 -> res_valid 4 edges after accept; sum_out=0x5555, c_out=0, overflow=0.
- a=0xFFFF, b=0x0000, c_in=1 -> carry ripples through all nibbles; sum_out=0x0000, c_out=1, overflow=0.
- a=0x7FFF, b=0x0001, c_in=0 -> sum_out=0x8000, c_out=0, overflow=1. Then a=0x8000, b=0x8000 -> sum_out=0x0000, c_out=1, overflow=1.
- Hold res_ready=0 for 10 cycles in DONE with start_valid=1 and changing operands -> res_valid stays 1, outputs stable, start_ready=0, no accept. Raise res_ready -> exactly one handshake; IDLE next cycle; the new operation is accepted one edge later.
- Deassert rst_n 2 cycles into RUN -> immediately all outputs 0, res_valid=0, start_ready=1. After release, a=0x0F0F, b=0x0101 -> sum_out=0x1010, c_out=0.
- start_valid and res_ready held high, two back-to-back ops -> accepts exactly 6 cycles (NIB+2) apart; both results correct and in order.
